// File: rtl/matrix_uart_formatter.sv
// matrix_uart_formatter
// Streams one stored m x n matrix as ASCII text to a byte-level UART transmitter.
// Elements are fetched row-major through a synchronous read port and converted to
// unsigned decimal without leading zeros. Numbers in a row are separated by a space,
// and each row ends in CR LF.
//
// Optional feature: define MATRIX_TX_HEADER_EN to send the header "<m> <n>\r\n"
// before row 0.
//
// Ports:
//   clk_i, rst_ni         clock; asynchronous active-low reset
//   start_i, m_i, n_i     print request, with the dimensions captured in idle
//   rd_en_o, rd_row_o,    storage read strobe and index; rd_data_i is valid
//   rd_col_o, rd_data_i   one cycle after rd_en_o
//   tx_data_o, tx_valid_o ASCII byte to uart_tx; the byte moves when
//   tx_ready_i            tx_valid_o and tx_ready_i are both high
//   busy_o, done_o, err_o status: busy while printing, a done pulse after the
//                         final LF, an err pulse on an illegal dimension
module matrix_uart_formatter #(
    parameter int unsigned MAX_DIM    = 5,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [3:0]            m_i,
    input  logic [3:0]            n_i,
    output logic                  rd_en_o,
    output logic [IDX_W-1:0]      rd_row_o,
    output logic [IDX_W-1:0]      rd_col_o,
    input  logic [ELEM_WIDTH-1:0] rd_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [3:0] {
        StIdle, StCheck, StHdr, StRd, StWt, StConv, StTxd, StTxSp, StTxCr, StTxLf, StFin
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            m_q, m_d, n_q, n_d;
    logic [IDX_W-1:0]      row_q, row_d, col_q, col_d;
    logic [ELEM_WIDTH-1:0] val_q, val_d;
    logic [3:0]            hund_q, hund_d, tens_q, tens_d;
    logic [1:0]            dig_q, dig_d;
    logic [2:0]            hdr_q, hdr_d;

    logic       last_col, last_row, dim_bad, tx_fire;
    logic [3:0] digit;

    assign last_col = (4'(col_q) == n_q - 4'd1);
    assign last_row = (4'(row_q) == m_q - 4'd1);
    assign dim_bad  = (m_q == 4'd0) || (n_q == 4'd0) ||
                      (m_q > 4'(MAX_DIM)) || (n_q > 4'(MAX_DIM));
    assign tx_fire  = tx_valid_o & tx_ready_i;

    // After conversion val_q holds the ones digit.
    always_comb begin
        digit = 4'd0;
        unique case (dig_q)
            2'd0:    digit = hund_q;
            2'd1:    digit = tens_q;
            default: digit = val_q[3:0];
        endcase
    end

    assign rd_row_o = row_q;
    assign rd_col_o = col_q;

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        val_d      = val_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        dig_d      = dig_q;
        hdr_d      = hdr_q;
        rd_en_o    = 1'b0;
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        busy_o     = (state_q != StIdle) && (state_q != StFin);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    m_d     = m_i;
                    n_d     = n_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (dim_bad) begin
                    err_o   = 1'b1;
                    busy_o  = 1'b0;
                    state_d = StIdle;
                end else begin
                    row_d   = '0;
                    col_d   = '0;
                    hdr_d   = 3'd0;
`ifdef MATRIX_TX_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StRd;
`endif
                end
            end
            StHdr: begin
                tx_valid_o = 1'b1;
                case (hdr_q)
                    3'd0:    tx_data_o = 8'h30 + {4'h0, m_q};
                    3'd1:    tx_data_o = 8'h20;
                    3'd2:    tx_data_o = 8'h30 + {4'h0, n_q};
                    3'd3:    tx_data_o = 8'h0D;
                    default: tx_data_o = 8'h0A;
                endcase
                if (tx_fire) begin
                    if (hdr_q == 3'd4) state_d = StRd;
                    else               hdr_d   = hdr_q + 3'd1;
                end
            end
            StRd: begin
                rd_en_o = 1'b1;
                state_d = StWt;
            end
            StWt: begin
                val_d   = rd_data_i;
                hund_d  = 4'd0;
                tens_d  = 4'd0;
                state_d = StConv;
            end
            StConv: begin
                if (val_q >= ELEM_WIDTH'(100)) begin
                    val_d  = val_q - ELEM_WIDTH'(100);
                    hund_d = hund_q + 4'd1;
                end else if (val_q >= ELEM_WIDTH'(10)) begin
                    val_d  = val_q - ELEM_WIDTH'(10);
                    tens_d = tens_q + 4'd1;
                end else begin
                    // First printed digit: skip leading zeros, ones always prints.
                    if (hund_q != 4'd0)      dig_d = 2'd0;
                    else if (tens_q != 4'd0) dig_d = 2'd1;
                    else                     dig_d = 2'd2;
                    state_d = StTxd;
                end
            end
            StTxd: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h30 + {4'h0, digit};
                if (tx_fire) begin
                    if (dig_q == 2'd2) state_d = last_col ? StTxCr : StTxSp;
                    else               dig_d   = dig_q + 2'd1;
                end
            end
            StTxSp: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h20;
                if (tx_fire) begin
                    col_d   = col_q + IDX_W'(1);
                    state_d = StRd;
                end
            end
            StTxCr: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0D;
                if (tx_fire) state_d = StTxLf;
            end
            StTxLf: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0A;
                if (tx_fire) begin
                    // Indices stay on the last element once the matrix is done.
                    if (last_row) begin
                        state_d = StFin;
                    end else begin
                        row_d   = row_q + IDX_W'(1);
                        col_d   = '0;
                        state_d = StRd;
                    end
                end
            end
            StFin: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            val_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            dig_q   <= '0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            val_q   <= val_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            dig_q   <= dig_d;
            hdr_q   <= hdr_d;
        end
    end

endmodule

// File: tb/tb_matrix_uart_formatter.sv
// Scoreboard bench for matrix_uart_formatter: the stimulus pushes the expected bytes,
// and a negedge monitor pops them and compares each byte as it is accepted.
module tb_matrix_uart_formatter;

`ifdef MATRIX_TX_HEADER_EN
    localparam int HdrLen = 5;
`else
    localparam int HdrLen = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] m_in, n_in;
    logic       rd_en;
    logic [2:0] rd_row, rd_col;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy, done, err;

    logic [7:0] mem [0:4][0:4];
    logic [7:0] exp_q [$];

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0, vcnt = 0, rdcnt = 0, bytes = 0;
    logic       pending = 1'b0;
    logic [7:0] held;
    bit         stall_en = 1'b0;

    matrix_uart_formatter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .m_i        (m_in),
        .n_i        (n_in),
        .rd_en_o    (rd_en),
        .rd_row_o   (rd_row),
        .rd_col_o   (rd_col),
        .rd_data_i  (rd_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Synchronous storage model: data appears the cycle after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_row][rd_col];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (tx_valid) vcnt++;
            if (rd_en) rdcnt++;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
            end
            if (pending) begin
                check("valid_held_while_stalled", tx_valid, 1);
                check("data_stable_while_stalled", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
                bytes++;
                pending = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %0h expected no byte", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end else if (tx_valid) begin
                pending = 1'b1;
                held    = tx_data;
            end
        end
    end

    // Ready driver: with stall_en, every 3rd byte sees tx_ready low for 7 cycles.
    int  acc = 0, stall = 0;
    bit  fire;
    always begin
        @(negedge clk);
        fire = tx_valid && tx_ready;
        @(posedge clk);
        #1;
        if (!stall_en) begin
            acc = 0; stall = 0; tx_ready = 1'b1;
        end else begin
            if (fire) begin
                acc++;
                if (acc % 3 == 2) stall = 7;
            end
            if (stall > 0) begin
                stall--;
                tx_ready = 1'b0;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    task automatic push_num(input int v);
        if (v >= 100) exp_q.push_back(8'h30 + 8'(v / 100));
        if (v >= 10)  exp_q.push_back(8'h30 + 8'((v / 10) % 10));
        exp_q.push_back(8'h30 + 8'(v % 10));
    endtask

    task automatic build(input int m, input int n);
        if (HdrLen != 0) begin
            exp_q.push_back(8'h30 + 8'(m));
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h30 + 8'(n));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                push_num(int'(mem[r][c]));
                if (c < n - 1) exp_q.push_back(8'h20);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic pulse_start(input int m, input int n);
        @(posedge clk); #1;
        start = 1'b1; m_in = 4'(m); n_in = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // poke >= 0: pulse start with a 1x1 request that many cycles into the run.
    task automatic run(input int m, input int n, input int poke);
        int b0, nexp;
        build(m, n);
        nexp     = exp_q.size();
        b0       = bytes;
        done_cnt = 0;
        pulse_start(m, n);
        for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            start = (c == poke);
            if (c == poke) begin m_in = 4'd1; n_in = 4'd1; end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("bytes_left", exp_q.size(), 0);
        check("byte_count", bytes - b0, nexp);
        check("busy_after_done", busy, 0);
        check("rd_row_hold", rd_row, m - 1);
        check("rd_col_hold", rd_col, n - 1);
        exp_q.delete();
    endtask

    task automatic run_err(input int m, input int n);
        int v0, r0, e0;
        v0 = vcnt; r0 = rdcnt; e0 = err_cnt;
        pulse_start(m, n);
        repeat (10) @(posedge clk);
        #1;
        check("err_pulses", err_cnt - e0, 1);
        check("err_no_tx_valid", vcnt - v0, 0);
        check("err_no_rd_en", rdcnt - r0, 0);
        check("err_busy_low", busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        rst_n = 1'b0; start = 1'b0; m_in = 4'd0; n_in = 4'd0;
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mem[r][c] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_row", rd_row, 0);
        check("rst_rd_col", rd_col, 0);
        rst_n = 1'b1;

        // 2x3 {1,2,3;4,5,6}
        for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) mem[r][c] = 8'(r * 3 + c + 1);
        run(2, 3, -1);

        // 1x3 {0,10,255}
        mem[0][0] = 8'd0; mem[0][1] = 8'd10; mem[0][2] = 8'd255;
        run(1, 3, -1);

        // 2x2 {1,2;3,4} with a start pulse while busy
        mem[0][0] = 8'd1; mem[0][1] = 8'd2; mem[1][0] = 8'd3; mem[1][1] = 8'd4;
        run(2, 2, 4);

        // 5x5 all 9 under tx_ready stalls
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mem[r][c] = 8'd9;
        stall_en = 1'b1;
        run(5, 5, -1);
        stall_en = 1'b0;

        run_err(6, 2);
        run_err(3, 0);

        // Reset in the middle of row 1 of a 2x3 print
        for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) mem[r][c] = 8'(r * 3 + c + 1);
        build(2, 3);
        b0 = bytes;
        pulse_start(2, 3);
        for (int c = 0; c < 2000 && (bytes - b0) < HdrLen + 8; c++) begin
            @(posedge clk); #1;
        end
        check("reached_row1", (bytes - b0) >= HdrLen + 8, 1);
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_tx_valid", tx_valid, 0);
        check("reset_drops_busy", busy, 0);
        check("reset_drops_rd_en", rd_en, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem[0][0] = 8'd7;
        run(1, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
